// File: rtl/vga_pixel_out_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_out_if
// Purpose  : Signal bundle between the pixel-address generator / VGA timing /
//            image BRAM and the pixel output stage.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_pixel_out_if #(
    parameter int ADDR_W = 17
);
    // Upstream pixel stream, aligned as described on each signal.
    logic [ADDR_W-1:0] pixel_addr;     // one cycle behind h_cnt/v_cnt
    logic              detect_doodle;  // aligned with pixel_addr
    logic              active_in;      // aligned with h_cnt/v_cnt
    logic              hsync_in;       // active-low, aligned with h_cnt/v_cnt
    logic              vsync_in;       // active-low, aligned with h_cnt/v_cnt

    // Image BRAM read port.
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;

    // VGA pins and game timing.
    logic [3:0]        vga_r;
    logic [3:0]        vga_g;
    logic [3:0]        vga_b;
    logic              hsync;
    logic              vsync;
    logic              frame_tick;
    logic [15:0]       frame_cnt;

    // Environment side: drives the stream and BRAM data, observes the pins.
    modport master (
        output pixel_addr, detect_doodle, active_in, hsync_in, vsync_in,
        output rom_data,
        input  rom_addr,
        input  vga_r, vga_g, vga_b, hsync, vsync, frame_tick, frame_cnt
    );

    // Pixel output stage side.
    modport slave (
        input  pixel_addr, detect_doodle, active_in, hsync_in, vsync_in,
        input  rom_data,
        output rom_addr,
        output vga_r, vga_g, vga_b, hsync, vsync, frame_tick, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_out
// Purpose  : VGA pixel output stage. Issues the image BRAM read, applies
//            colour-key transparency to sprite pixels, blanks outside the
//            active area, keeps hsync/vsync pixel-aligned with RGB and
//            produces a per-frame tick and frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_out #(
    parameter int          ADDR_W     = 17,
    parameter int          SYNC_DELAY = 4,        // legal 3..8
    parameter logic [11:0] KEY_COLOR  = 12'h0F0,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    vga_pixel_out_if.slave bus
);

    // Depth of the sync/active shift registers; the final pin register adds
    // the last cycle so syncs leave together with RGB.
    localparam int c_DLY = SYNC_DELAY - 1;

    logic [c_DLY-1:0]  r_hs_dly;
    logic [c_DLY-1:0]  r_vs_dly;
    logic [c_DLY-1:0]  r_act_dly;

    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_spr_d1;
    logic              r_spr_d2;

    logic [11:0]       w_rgb_next;
    logic [11:0]       r_rgb;
    logic              r_hsync;
    logic              r_vsync;

    logic              w_tick_next;
    logic [15:0]       w_frame_cnt_next;
    logic              r_frame_tick;
    logic [15:0]       r_frame_cnt;

    // Sync and active delay lines; syncs reset inactive (high), active to blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_dly  <= '1;
            r_vs_dly  <= '1;
            r_act_dly <= '0;
        end else begin
            r_hs_dly  <= {r_hs_dly[c_DLY-2:0],  bus.hsync_in};
            r_vs_dly  <= {r_vs_dly[c_DLY-2:0],  bus.vsync_in};
            r_act_dly <= {r_act_dly[c_DLY-2:0], bus.active_in};
        end
    end

    // Stage 1: register the BRAM read address and the sprite flag with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_spr_d1   <= 1'b0;
        end else begin
            r_rom_addr <= bus.pixel_addr;
            r_spr_d1   <= bus.detect_doodle;
        end
    end

    // Stage 2: the BRAM output register holds the pixel data, so only the
    // sprite flag needs delaying here to stay aligned with rom_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spr_d2 <= 1'b0;
        end else begin
            r_spr_d2 <= r_spr_d1;
        end
    end

    // Colour select: blank outside the active area, key out sprite pixels.
    always_comb begin
        w_rgb_next = bus.rom_data;
        if (!r_act_dly[c_DLY-1]) begin
            w_rgb_next = 12'h000;
        end else if (r_spr_d2 && (bus.rom_data == KEY_COLOR)) begin
            w_rgb_next = BG_COLOR;
        end
    end

    // Stage 3: pin registers for RGB and both syncs, updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb   <= 12'h000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_rgb_next;
            r_hsync <= r_hs_dly[c_DLY-1];
            r_vsync <= r_vs_dly[c_DLY-1];
        end
    end

    // Frame edge detect: pin vsync high now and about to go low.
    always_comb begin
        w_tick_next      = r_vsync & ~r_vs_dly[c_DLY-1];
        w_frame_cnt_next = r_frame_cnt + {15'd0, w_tick_next};
    end

    // Frame tick and counter registers; the counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_frame_tick <= w_tick_next;
            r_frame_cnt  <= w_frame_cnt_next;
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.vga_r      = r_rgb[11:8];
    assign bus.vga_g      = r_rgb[7:4];
    assign bus.vga_b      = r_rgb[3:0];
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.frame_tick = r_frame_tick;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_out
// Purpose  : Self-checking bench for vga_pixel_out. A cycle-indexed history
//            of the inputs is turned into expected pin values using the
//            end-to-end latency rules of the block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_out;

    localparam int          ADDR_W = 17;
    localparam logic [11:0] c_KEY  = 12'h0F0;
    localparam logic [11:0] c_BG   = 12'h000;
    localparam int          c_HMAX = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vga_pixel_out_if #(.ADDR_W(ADDR_W)) bus ();

    vga_pixel_out #(
        .ADDR_W     (ADDR_W),
        .SYNC_DELAY (4),
        .KEY_COLOR  (c_KEY),
        .BG_COLOR   (c_BG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Image BRAM model: one-cycle registered read.
    logic [11:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    // Input history, indexed by the cycle in which the value was driven.
    bit              h_rst  [c_HMAX];
    bit              h_act  [c_HMAX];
    bit              h_hs   [c_HMAX];
    bit              h_vs   [c_HMAX];
    bit              h_spr  [c_HMAX];
    logic [16:0]     h_addr [c_HMAX];

    int          t      = 0;
    int          errors = 0;
    int          checks = 0;
    int          ticks  = 0;
    logic [15:0] m_cnt  = 16'd0;
    bit          m_vs_prev = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Cycles before the bench started count as reset.
    function automatic bit rst_at(input int i);
        return (i < 0) ? 1'b1 : h_rst[i];
    endfunction

    // Drive one cycle of inputs, clock it, then compare the pins.
    task automatic step(input bit r, input bit a, input bit hs, input bit vs,
                        input logic [16:0] addr, input bit spr);
        bit          in_rst;
        bit          e_hs;
        bit          e_vs;
        bit          e_tick;
        logic [11:0] e_rgb;
        logic [11:0] d;
        logic [16:0] e_addr;
        if (t >= c_HMAX) begin
            $display("FAIL history_overflow: got %0d expected below %0d", t, c_HMAX);
            $fatal(1, "history overflow");
        end
        h_rst[t] = r; h_act[t] = a; h_hs[t] = hs; h_vs[t] = vs;
        h_addr[t] = addr; h_spr[t] = spr;
        rst               = r;
        bus.active_in     = a;
        bus.hsync_in      = hs;
        bus.vsync_in      = vs;
        bus.pixel_addr    = addr;
        bus.detect_doodle = spr;
        @(posedge clk);
        #1;
        // Pixel p = t-3 reaches the pins now; its address was driven at p+1.
        // Any reset in the last four cycles leaves the pins at reset values.
        in_rst = rst_at(t) | rst_at(t-1) | rst_at(t-2) | rst_at(t-3);
        e_hs   = in_rst ? 1'b1 : h_hs[t-3];
        e_vs   = in_rst ? 1'b1 : h_vs[t-3];
        if (in_rst || !h_act[t-3]) begin
            e_rgb = 12'h000;
        end else begin
            d     = mem[h_addr[t-2]];
            e_rgb = (h_spr[t-2] && d == c_KEY) ? c_BG : d;
        end
        e_tick = !rst_at(t) && m_vs_prev && !e_vs;
        m_cnt  = rst_at(t) ? 16'd0 : m_cnt + (e_tick ? 16'd1 : 16'd0);
        m_vs_prev = e_vs;
        e_addr = rst_at(t) ? 17'd0 : h_addr[t];
        chk("rgb",        32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e_rgb));
        chk("hsync",      32'(bus.hsync),      32'(e_hs));
        chk("vsync",      32'(bus.vsync),      32'(e_vs));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
        chk("frame_cnt",  32'(bus.frame_cnt),  32'(m_cnt));
        chk("rom_addr",   32'(bus.rom_addr),   32'(e_addr));
        if (bus.frame_tick) ticks++;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 1'b0);
    endtask

    task automatic vs_pulse(input int low_len, input int high_len);
        for (int i = 0; i < low_len; i++)  step(1'b0, 1'b0, 1'b1, 1'b0, 17'd5, 1'b0);
        for (int i = 0; i < high_len; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 17'd5, 1'b0);
    endtask

    initial begin
        int          vs_left;
        bit          vs_cur;
        logic [16:0] ra;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 12'($urandom);
        mem[62400] = 12'hABC;
        mem[100]   = 12'h0F0;
        mem[101]   = 12'h0F0;
        mem[102]   = 12'h0F1;
        mem[103]   = 12'hFFF;

        // Reset with vsync_in low, then release: vsync falls 4 cycles later.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b0);
        chk("reset_cnt", 32'(bus.frame_cnt), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 17'd0, 1'b0);
        idle(6);

        // Latency: active at cycle 0, address at cycle 1.
        step(1'b0, 1'b1, 1'b1, 1'b1, 17'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 17'd62400, 1'b0);
        chk("lat_rom_addr", 32'(bus.rom_addr), 32'd62400);
        step(1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 1'b0);
        chk("lat_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0ABC);
        idle(4);

        // Transparency: keyed sprite, keyed non-sprite, near-key sprite.
        step(1'b0, 1'b1, 1'b1, 1'b1, 17'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 17'd100, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 17'd101, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 17'd102, 1'b1);
        idle(4);

        // Blanking with white data, then a single-cycle active pulse.
        step(1'b0, 1'b0, 1'b1, 1'b1, 17'd103, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 17'd103, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 17'd103, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 17'd103, 1'b0);
        idle(5);

        // Three frames after a fresh reset.
        step(1'b1, 1'b0, 1'b1, 1'b1, 17'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 17'd0, 1'b0);
        ticks = 0;
        vs_pulse(2, 5);
        vs_pulse(1, 5);
        vs_pulse(3, 8);
        chk("three_ticks", 32'(ticks), 32'd3);
        chk("three_frames", 32'(bus.frame_cnt), 32'd3);

        // Counter wrap from all-ones.
        force dut.r_frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        idle(1);
        release dut.r_frame_cnt;
        idle(1);
        vs_pulse(2, 6);
        chk("wrap_cnt", 32'(bus.frame_cnt), 32'd0);

        // Mid-frame reset during an active line with vsync high.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 17'(i + 200), 1'b0);
        ticks = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 17'd300, 1'b0);
        chk("midrst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
        chk("midrst_syncs", 32'({bus.hsync, bus.vsync}), 32'd3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 17'(i + 400), 1'b1);
        chk("midrst_no_tick", 32'(ticks), 32'd0);

        // Randomized traffic with run-length vsync and occasional resets.
        vs_left = 5;
        vs_cur  = 1'b1;
        for (int i = 0; i < 2200; i++) begin
            if (vs_left == 0) begin
                vs_cur  = ~vs_cur;
                vs_left = vs_cur ? int'($urandom_range(2, 20)) : int'($urandom_range(1, 6));
            end
            vs_left--;
            if ($urandom_range(0, 2) == 0) ra = 17'($urandom_range(100, 103));
            else                           ra = 17'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), vs_cur, ra, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pixel_out.md
Name: vga_pixel_out

Overview:
- Pixel output stage. It sits between the pixel-address generator and the VGA pins.
- It consumes the registered image-ROM address and sprite flag, issues the block-RAM read, and applies colour-key transparency to sprite pixels.
- It forces blanking outside the active area, delays hsync/vsync/active to stay pixel-aligned with RGB, and drives 12-bit RGB.
- It also produces a per-frame tick and frame counter used by game timing.

Parameters:
- ADDR_W, 17, image-ROM address width.
- SYNC_DELAY, 4, total cycles from h_cnt/v_cnt to the RGB pins. Equals 1 (address-generator register) + 3 (this block). Legal range 3..8.
- KEY_COLOR, 12'h0F0, sprite transparency key in RGB444.
- BG_COLOR, 12'h000, colour substituted for keyed sprite pixels.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pixel_addr  in  ADDR_W  ROM address from address generator; already one cycle behind h_cnt/v_cnt.
- detect_doodle  in  1  sprite flag, aligned with pixel_addr.
- active_in  in  1  display-area flag from VGA timing; aligned with h_cnt/v_cnt.
- hsync_in  in  1  active-low hsync; aligned with h_cnt/v_cnt.
- vsync_in  in  1  active-low vsync; aligned with h_cnt/v_cnt.
- rom_addr  out  ADDR_W  registered BRAM read address.
- rom_data  in  12  BRAM read data; valid exactly one cycle after rom_addr.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.
- hsync  out  1  delayed hsync_in.
- vsync  out  1  delayed vsync_in.
- frame_tick  out  1  one-cycle pulse at start of each vsync pulse.
- frame_cnt  out  16  frames since reset.

Behaviour:
- Reset values:
  - rom_addr=0; vga_r/g/b=0.
  - hsync=1, vsync=1 (inactive).
  - frame_tick=0, frame_cnt=0.
  - All delay-line stages load 1 for sync lines and 0 for active and sprite lines.
  - Reset mid-frame takes effect on the next edge. Output stays blank with syncs high until real inputs propagate, i.e. SYNC_DELAY cycles after rst deasserts.
- Pipeline (h_cnt at cycle n; pixel_addr arrives at n+1):
  - S1 (edge end of n+1): rom_addr <= pixel_addr; spr_d1 <= detect_doodle.
  - S2 (n+2): rom_data valid; spr_d2 <= spr_d1; pix_d <= rom_data.
  - S3 (n+3): colour select registered onto vga_r/g/b.
- Colour select, evaluated on stage-3 inputs:
  - If act_d (active_in delayed to match) = 0: RGB = 12'h000.
  - Else if spr_d2 = 1 and pix_d == KEY_COLOR: RGB = BG_COLOR.
  - Else: RGB = pix_d.
- Key colour on non-sprite pixels (spr=0) passes through unchanged.
- Sync/active delay:
  - hsync_in, vsync_in, active_in each pass through a shift register of depth SYNC_DELAY-1.
  - Sync outputs are then registered in parallel with RGB, giving total latency SYNC_DELAY from input to pin.
  - With default 4, RGB for pixel n and its sync level appear together at edge n+4 relative to the VGA counters.
- Frame counter:
  - Edge detect on the delayed vsync (pin-side): prev=1, cur=0 gives frame_tick=1 for exactly one cycle, aligned with the vsync falling edge on the pin.
  - frame_cnt increments in the same cycle and wraps 16'hFFFF -> 0.
  - No tick on the first cycle after reset, because reset loads prev=1 and cur=1.
- Stall: none. The block accepts one pixel per clock unconditionally; BRAM latency is fixed at 1.
- All arithmetic is width-exact; no truncation of pixel_addr.

Test Plan:
- Reset: hold rst 3 cycles with vsync_in=0 -> hsync=vsync=1, RGB=0, frame_cnt=0, no frame_tick; release -> vsync goes 0 exactly 4 cycles after the first sampled vsync_in=0, and frame_tick pulses once on that same edge.
- Latency: drive pixel_addr=17'd62400 at cycle 1 with active_in=1 at cycle 0 and BRAM model returning 12'hABC -> rom_addr=62400 after edge 1; vga_r=A, vga_g=B, vga_b=C at edge 4.
- Transparency: detect_doodle=1, rom_data=12'h0F0 -> RGB=BG_COLOR (000). Same data with detect_doodle=0 -> RGB=0F0. detect_doodle=1 with data 12'h0F1 -> 0F1.
- Blanking: active_in=0 with rom_data=12'hFFF -> RGB=000 at the aligned cycle. A single-cycle active_in toggle produces exactly one coloured pixel at latency 4.
- Frame count: apply 3 vsync_in low pulses -> 3 frame_tick pulses, each 1 cycle wide, and frame_cnt=3. Preload frame_cnt to 16'hFFFF via force, then one vsync -> frame_cnt=0.
- Mid-frame reset: assert rst during the active line while vsync_in=1 -> next edge gives RGB=000 and syncs high, with no spurious frame_tick on release.
